// File: rtl/mdu_if.sv
// mdu_if: operand/strobe/result bundle between the EX stage and the multiply/divide unit
//   master drives A, B, MDUOp, Start; slave (mdu_unit) drives Busy, HI, LO
interface mdu_if;
   logic [31:0] A;
   logic [31:0] B;
   logic [2:0]  MDUOp;
   logic        Start;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;
   modport master (output A, B, MDUOp, Start, input Busy, HI, LO);
   modport slave (input A, B, MDUOp, Start, output Busy, HI, LO);
endinterface

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle MULT/MULTU/DIV/DIVU unit holding architectural HI/LO
//   clk, reset (async active-high); bus: A, B, MDUOp, Start in; Busy, HI, LO out
//   optional MDU_MADD_EN: MDUOp 111 accumulates signed A*B into {HI,LO}
module mdu_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic  clk,
   input logic  reset,
   mdu_if.slave bus
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t      state, nxt;
   logic [31:0] cnt, shi, slo, hi, lo;
   logic        wr;
   logic        is_mul, is_div, go, done, sm, sd;
   logic [63:0] sa, sb, prod, res;
   logic [31:0] ua, ub, uq, ur, q, r;
   always_comb begin
      is_div = bus.MDUOp == 3'b011 || bus.MDUOp == 3'b100;
`ifdef MDU_MADD_EN
      is_mul = bus.MDUOp == 3'b001 || bus.MDUOp == 3'b010 || bus.MDUOp == 3'b111;
`else
      is_mul = bus.MDUOp == 3'b001 || bus.MDUOp == 3'b010;
`endif
      go   = state == IDLE && bus.Start && (is_mul || is_div);
      done = state == RUN && cnt == 32'd0;
      sm   = bus.MDUOp != 3'b010;
      sd   = bus.MDUOp == 3'b011;
      // low 64 bits of the sign-extended product equal the signed 64-bit product
      sa   = {{32{sm & bus.A[31]}}, bus.A};
      sb   = {{32{sm & bus.B[31]}}, bus.B};
      prod = sa * sb;
      // signed divide on magnitudes: avoids the 0x80000000/-1 overflow case and wraps naturally
      ua   = sd && bus.A[31] ? -bus.A : bus.A;
      ub   = sd && bus.B[31] ? -bus.B : bus.B;
      uq   = ub == 32'd0 ? 32'd0 : ua / ub;
      ur   = ub == 32'd0 ? 32'd0 : ua % ub;
      q    = sd && (bus.A[31] ^ bus.B[31]) ? -uq : uq;
      r    = sd && bus.A[31] ? -ur : ur;
`ifdef MDU_MADD_EN
      res  = is_div ? {r, q} : bus.MDUOp == 3'b111 ? {hi, lo} + prod : prod;
`else
      res  = is_div ? {r, q} : prod;
`endif
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= nxt;
   always_comb
      nxt = state == IDLE ? (go ? RUN : IDLE) : (done ? IDLE : RUN);
   always_comb begin
      bus.Busy = state == RUN;
      bus.HI   = hi;
      bus.LO   = lo;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt <= '0;
         shi <= '0;
         slo <= '0;
         wr  <= 1'b0;
         hi  <= '0;
         lo  <= '0;
      end else begin
         if (go) begin
            shi <= res[63:32];
            slo <= res[31:0];
            // divide by zero runs the full latency but leaves HI/LO untouched
            wr  <= !(is_div && bus.B == 32'd0);
            cnt <= is_div ? 32'(DIV_CYCLES - 1) : 32'(MULT_CYCLES - 1);
         end else if (state == RUN && cnt != 32'd0) cnt <= cnt - 32'd1;
         if (done && wr) begin
            hi <= shi;
            lo <= slo;
         end
         if (state == IDLE && bus.Start && bus.MDUOp == 3'b101) hi <= bus.A;
         if (state == IDLE && bus.Start && bus.MDUOp == 3'b110) lo <= bus.A;
      end
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed vector table plus hand sequences for mdu_unit
module tb_mdu_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   mdu_if bus();
   mdu_unit dut (.clk(clk), .reset(reset), .bus(bus.slave));
   typedef struct {
      logic [2:0]  op;
      logic [31:0] a, b, phi, plo;
      int          cyc;
      logic [31:0] hi, lo;
   } vec_t;
   vec_t v[14];
   int n_cmp = 0;
   int n_bad = 0;
   int n;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.MDUOp = op;
      bus.A = a;
      bus.B = b;
      bus.Start = 1'b1;
      @(negedge clk);
      bus.Start = 1'b0;
      bus.MDUOp = 3'd0;
      bus.A = $urandom;
      bus.B = $urandom;
   endtask
   task automatic wait_idle(output int cnt);
      cnt = 0;
      while (bus.Busy && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
   endtask
   initial begin
      v[0]  = '{3'b001, 32'hFFFFFFFE, 32'd3,        32'h0, 32'h0, 5,  32'hFFFFFFFF, 32'hFFFFFFFA};
      v[1]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'h0, 32'h0, 5,  32'h00000001, 32'hFFFFFFFE};
      v[2]  = '{3'b011, 32'hFFFFFFF9, 32'd2,        32'h1, 32'h2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
      v[3]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'h1, 32'h2, 10, 32'h00000001, 32'h7FFFFFFC};
      v[4]  = '{3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h6, 10, 32'h00000000, 32'h80000000};
      v[5]  = '{3'b100, 32'h00001234, 32'd0,        32'hAAAA0000, 32'h5555, 10, 32'hAAAA0000, 32'h00005555};
      v[6]  = '{3'b011, 32'h00000007, 32'd0,        32'h77, 32'h88, 10, 32'h00000077, 32'h00000088};
      v[7]  = '{3'b101, 32'h12345678, 32'h0,        32'h0, 32'h9, 0,  32'h12345678, 32'h00000009};
      v[8]  = '{3'b110, 32'hCAFEF00D, 32'h0,        32'h3, 32'h4, 0,  32'h00000003, 32'hCAFEF00D};
      v[9]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hA, 32'hB, 0,  32'h0000000A, 32'h0000000B};
      v[10] = '{3'b001, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 32'h0, 5,  32'h3FFFFFFF, 32'h00000001};
      v[11] = '{3'b011, 32'h00000007, 32'hFFFFFFFE, 32'h0, 32'h0, 10, 32'h00000001, 32'hFFFFFFFD};
      v[12] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h9, 32'h9, 5,  32'h00000000, 32'h00000001};
`ifdef MDU_MADD_EN
      v[13] = '{3'b111, 32'h1, 32'h1, 32'h0, 32'hFFFFFFFF, 5, 32'h00000001, 32'h00000000};
`else
      v[13] = '{3'b111, 32'h1, 32'h1, 32'h0, 32'hFFFFFFFF, 0, 32'h00000000, 32'hFFFFFFFF};
`endif
      bus.Start = 1'b0;
      bus.MDUOp = 3'd0;
      bus.A = '0;
      bus.B = '0;
      #12;
      chk("reset_busy", 32'(bus.Busy), 32'd0);
      chk("reset_hi", bus.HI, 32'd0);
      chk("reset_lo", bus.LO, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 14; i++) begin
         issue(3'b101, v[i].phi, 32'h0);
         issue(3'b110, v[i].plo, 32'h0);
         issue(v[i].op, v[i].a, v[i].b);
         wait_idle(n);
         chk($sformatf("v%0d_cycles", i), 32'(n), 32'(v[i].cyc));
         chk($sformatf("v%0d_hi", i), bus.HI, v[i].hi);
         chk($sformatf("v%0d_lo", i), bus.LO, v[i].lo);
      end
      // Start while busy (MTLO then MULT) must be ignored during a DIV
      issue(3'b101, 32'h0, 32'h0);
      issue(3'b110, 32'h0, 32'h0);
      issue(3'b011, 32'hFFFFFFF9, 32'd2);
      n = 0;
      while (bus.Busy && n < 100) begin
         bus.Start = n == 3 || n == 4;
         bus.MDUOp = n == 3 ? 3'b110 : 3'b001;
         bus.A = 32'h00000BAD;
         bus.B = 32'h00000BAD;
         @(negedge clk);
         n++;
      end
      bus.Start = 1'b0;
      bus.MDUOp = 3'd0;
      chk("busy_ign_cycles", 32'(n), 32'd10);
      chk("busy_ign_hi", bus.HI, 32'hFFFFFFFF);
      chk("busy_ign_lo", bus.LO, 32'hFFFFFFFD);
      repeat (3) @(negedge clk);
      chk("busy_ign_idle", 32'(bus.Busy), 32'd0);
      chk("busy_ign_lo2", bus.LO, 32'hFFFFFFFD);
      // async reset in the third cycle of a MULT
      issue(3'b101, 32'h11111111, 32'h0);
      issue(3'b001, 32'hFFFFFFFE, 32'd3);
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("rst_mid_busy", 32'(bus.Busy), 32'd0);
      chk("rst_mid_hi", bus.HI, 32'd0);
      chk("rst_mid_lo", bus.LO, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      chk("rst_late_busy", 32'(bus.Busy), 32'd0);
      chk("rst_late_hi", bus.HI, 32'd0);
      chk("rst_late_lo", bus.LO, 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, beside the combinational ALU.
- Takes the same operand pair (A = rs value, B = rt value) under a start strobe and runs multi-cycle MULT/DIV.
- Holds the architectural HI/LO registers and raises Busy so the hazard unit stalls later HI/LO users (mfhi/mflo/mult/div/mthi/mtlo).

Parameters:
- MULT_CYCLES, 5, Busy duration in cycles for multiply ops (>=1)
- DIV_CYCLES, 10, Busy duration in cycles for divide ops (>=1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- A  input  32  operand 1 (rs value; dividend; multiplicand; MTHI/MTLO data)
- B  input  32  operand 2 (rt value; divisor; multiplier)
- MDUOp  input  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 MADD (only with option)
- Start  input  1  one-cycle strobe; A/B/MDUOp are valid in this cycle
- Busy  output  1  operation in flight
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register

Behaviour:
- Reset is asynchronous and active-high; one clock, clk.
- Reset values: HI=0, LO=0, Busy=0, FSM=IDLE, counter=0, shadow result=0.
- FSM states:
  - IDLE: no operation in flight.
  - RUN: operation in flight.
- In IDLE, Start=1 with MULT/MULTU/DIV/DIVU/MADD:
  - Operands are captured at the edge.
  - The full result is computed into shadow regs {sHI,sLO}.
  - Counter loads N-1, with N = MULT_CYCLES or DIV_CYCLES.
  - FSM goes to RUN.
- In RUN:
  - Busy=1 for exactly N cycles following the start edge.
  - At the edge where counter==0, HI<=sHI, LO<=sLO, Busy falls and FSM returns to IDLE.
  - New HI/LO values are visible in the first cycle with Busy=0.
- MTHI/MTLO in IDLE:
  - HI<=A (or LO<=A) at the Start edge.
  - Busy stays 0; latency is 1 edge.
- MDUOp=000, or 111 with the option disabled, under Start: no effect.
- Start while Busy=1: ignored entirely, including MTHI/MTLO. The stall logic guarantees this never happens; the unit is still required to be robust to it.
- Arithmetic:
  - MULT: {HI,LO} = signed 64-bit A*B.
  - MULTU: {HI,LO} = unsigned 64-bit A*B.
  - DIV: LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps, no trap).
  - Divide by zero (DIV or DIVU): the unit still goes Busy for DIV_CYCLES, but HI/LO keep their prior values at completion.
- HI/LO change only at completion, on MTHI/MTLO, or on reset.
- Reset asserted mid-operation: the operation is aborted, Busy drops immediately (asynchronously), and HI/LO clear to 0.
- A/B/MDUOp may change freely after the Start cycle; the result depends only on the values captured at the Start edge.

Optional Feature:
- Macro MDU_MADD_EN.
- When defined:
  - MDUOp=111 is MADD: {HI,LO} <= {HI,LO} + signed(A)*signed(B), modulo 2^64.
  - Uses MULT_CYCLES.
  - The accumulator base is the HI/LO value at the Start edge.
- When undefined:
  - 111 is a no-op and Busy stays 0.
  - No accumulate adder is synthesized.

Test Plan:
- Reset, then MULT A=0xFFFFFFFE(-2), B=3 -> Busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA, Busy=0.
- MULTU A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9(-7), B=2 -> Busy exactly 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also:
  - DIVU on the same operands gives LO=0x7FFFFFFC, HI=1.
  - DIV 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
- MTHI A=0x12345678 while idle -> HI=0x12345678 after one edge with Busy never high. Then MTLO during a running DIV -> ignored, and the DIV result lands unchanged.
- DIVU by 0 with HI=0xAAAA0000, LO=0x5555 preloaded -> Busy 10 cycles, then HI/LO unchanged. Assert reset in cycle 3 of a MULT -> Busy=0 and HI=LO=0 immediately, and no late write occurs.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then MADD A=1, B=1 -> HI=1, LO=0 after 5 cycles. Without the macro, the same stimulus -> no Busy and no change.
